// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: opcode constants,
// fetcher state encoding and the jump-kind classification helper.
package ifetch_pkg;

    localparam logic [7:0] OP_NOP  = 8'd2;
    localparam logic [7:0] OP_CLAC = 8'd7;
    localparam logic [7:0] OP_INAC = 8'd19;
    localparam logic [7:0] OP_JUMP = 8'd29;
    localparam logic [7:0] OP_JMPZ = 8'd32;
    localparam logic [7:0] OP_JMNZ = 8'd37;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_WAIT,
        ST_DECODE,
        ST_OPND_WAIT,
        ST_OPND,
        ST_ISSUE,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        JK_NONE,
        JK_JUMP,
        JK_JMPZ,
        JK_JMNZ
    } jump_kind_t;

    function automatic jump_kind_t classify_jump(input logic [7:0] opcode);
        case (opcode)
            OP_JUMP: return JK_JUMP;
            OP_JMPZ: return JK_JMPZ;
            OP_JMNZ: return JK_JMNZ;
            default: return JK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ifetch_jump_eval.sv
// Combinational taken/not-taken decision for a resolved two-byte jump.
module ifetch_jump_eval
    import ifetch_pkg::*;
(
    input  logic [1:0] kind,
    input  logic       z_flag,
    output logic       taken
);

    jump_kind_t jk;

    always_comb begin
        jk = jump_kind_t'(kind);
        case (jk)
            JK_JUMP: taken = 1'b1;
            JK_JMPZ: taken = z_flag;
            JK_JMNZ: taken = ~z_flag;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch sequencer: owns the PC, absorbs the one-cycle IRAM read
// latency, resolves jumps internally and issues other opcodes via valid/ready.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [7:0] START_ADDR  = 8'd0,
    parameter int         ROM_DEPTH   = 121,
    parameter bit         HALT_ON_NOP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] iram_addr,
    input  logic [7:0] iram_dout,
    input  logic       z_flag,
    output logic [7:0] instr_opcode,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic       jump_taken,
    output logic       halted,
    output logic       fault
);

    localparam logic [8:0] ROM_LIMIT = 9'(ROM_DEPTH);

    state_t     state, state_n;
    logic [7:0] pc, pc_n;
    jump_kind_t kind_q, kind_n;
    logic [7:0] opcode_n;
    logic       valid_n;
    logic       jt_n;
    logic       fault_n;

    logic       pc_oob;
    jump_kind_t dec_kind;
    logic       taken;

    // The PC wraps at 8 bits, so the bound is compared one bit wider.
    assign pc_oob    = {1'b0, pc} >= ROM_LIMIT;
    assign dec_kind  = classify_jump(iram_dout);
    assign iram_addr = pc;
    assign halted    = (state == ST_HALT);

    ifetch_jump_eval u_jump_eval (
        .kind   (kind_q),
        .z_flag (z_flag),
        .taken  (taken)
    );

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can
        // leave one unassigned and infer a latch.
        state_n  = state;
        pc_n     = pc;
        kind_n   = kind_q;
        opcode_n = instr_opcode;
        valid_n  = instr_valid;
        jt_n     = 1'b0;
        fault_n  = fault;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    pc_n    = START_ADDR;
                    state_n = ST_FETCH_WAIT;
                end
            end
            ST_FETCH_WAIT: begin
                if (pc_oob) begin
                    fault_n = 1'b1;
                    state_n = ST_HALT;
                end else begin
                    state_n = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_kind != JK_NONE) begin
                    kind_n  = dec_kind;
                    pc_n    = pc + 8'd1;
                    state_n = ST_OPND_WAIT;
                end else if (HALT_ON_NOP && iram_dout == OP_NOP) begin
                    state_n = ST_HALT;
                end else begin
                    opcode_n = iram_dout;
                    valid_n  = 1'b1;
                    pc_n     = pc + 8'd1;
                    state_n  = ST_ISSUE;
                end
            end
            ST_OPND_WAIT: begin
                if (pc_oob) begin
                    fault_n = 1'b1;
                    state_n = ST_HALT;
                end else begin
                    state_n = ST_OPND;
                end
            end
            ST_OPND: begin
                // z_flag is only consulted here, after the prior ALU op retired.
                if (taken) begin
                    pc_n = iram_dout;
                    jt_n = 1'b1;
                end else begin
                    pc_n = pc + 8'd1;
                end
                state_n = ST_FETCH_WAIT;
            end
            ST_ISSUE: begin
                if (instr_ready) begin
                    valid_n = 1'b0;
                    state_n = ST_FETCH_WAIT;
                end
            end
            ST_HALT: begin
                valid_n = 1'b0;
            end
            default: begin
                valid_n = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            pc           <= 8'd0;
            kind_q       <= JK_NONE;
            instr_opcode <= 8'd0;
            instr_valid  <= 1'b0;
            jump_taken   <= 1'b0;
            fault        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the values present before this edge.
            state        <= state_n;
            pc           <= pc_n;
            kind_q       <= kind_n;
            instr_opcode <= opcode_n;
            instr_valid  <= valid_n;
            jump_taken   <= jt_n;
            fault        <= fault_n;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: IRAM model, issue scoreboard,
// table-driven program runs and hand-written timing/back-pressure/reset cases.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] iram_addr;
    logic [7:0] iram_dout = 8'd0;
    logic       z_flag = 1'b0;
    logic [7:0] instr_opcode;
    logic       instr_valid;
    logic       instr_ready = 1'b1;
    logic       jump_taken;
    logic       halted;
    logic       fault;

    int n_total = 0;
    int n_bad   = 0;
    int jt_cnt  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rom [256];

    always #5 clk = ~clk;

    ifetch_unit #(.START_ADDR(8'd0), .ROM_DEPTH(121), .HALT_ON_NOP(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .iram_addr    (iram_addr),
        .iram_dout    (iram_dout),
        .z_flag       (z_flag),
        .instr_opcode (instr_opcode),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .jump_taken   (jump_taken),
        .halted       (halted),
        .fault        (fault)
    );

    // Synchronous IRAM: data for the address presented appears after the edge.
    always @(posedge clk) iram_dout <= rom[iram_addr];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: an accepted handshake pops the oldest expected opcode.
    always @(negedge clk) begin
        if (!rst) begin
            if (jump_taken) jt_cnt++;
            if (instr_valid && instr_ready) begin
                check("issue_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("issue_opcode", int'(instr_opcode), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic load_prog(input int sel);
        for (int i = 0; i < 256; i++) rom[i] = OP_NOP;
        if (sel == 0) begin
            rom[0] = OP_CLAC; rom[1] = OP_INAC; rom[2] = OP_NOP;
        end else begin
            rom[0]   = OP_JUMP; rom[1]   = 8'd103;
            rom[103] = OP_JMPZ; rom[104] = 8'd120;
            rom[105] = OP_JMNZ; rom[106] = 8'd118;
            rom[118] = OP_JUMP; rom[119] = 8'd21;
            rom[120] = OP_INAC;
            rom[21]  = OP_NOP;
        end
    endtask

    task automatic do_reset(input int sel);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0;
        #1;
        check("rst_addr",   int'(iram_addr), 0);
        check("rst_valid",  int'(instr_valid), 0);
        check("rst_opcode", int'(instr_opcode), 0);
        check("rst_jt",     int'(jump_taken), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_fault",  int'(fault), 0);
        load_prog(sel);
        exp_q.delete();
        jt_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic pulse_start(input bit hold);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_halted(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", int'(halted), 1);
    endtask

    typedef struct {
        int         prog;
        bit         z;
        bit         hold_start;
        int         n_exp;
        logic [7:0] exp0;
        logic [7:0] exp1;
        int         exp_pc;
        int         exp_fault;
        int         exp_jt;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int cyc;

        vecs[0] = '{prog: 0, z: 1'b0, hold_start: 1'b1, n_exp: 2, exp0: OP_CLAC, exp1: OP_INAC,
                    exp_pc: 2, exp_fault: 0, exp_jt: 0};
        vecs[1] = '{prog: 1, z: 1'b1, hold_start: 1'b0, n_exp: 1, exp0: OP_INAC, exp1: 8'd0,
                    exp_pc: 121, exp_fault: 1, exp_jt: 2};
        vecs[2] = '{prog: 1, z: 1'b0, hold_start: 1'b0, n_exp: 0, exp0: 8'd0, exp1: 8'd0,
                    exp_pc: 21, exp_fault: 0, exp_jt: 3};

        for (int v = 0; v < 3; v++) begin
            do_reset(vecs[v].prog);
            z_flag = vecs[v].z;
            instr_ready = 1'b1;
            if (vecs[v].n_exp > 0) exp_q.push_back(vecs[v].exp0);
            if (vecs[v].n_exp > 1) exp_q.push_back(vecs[v].exp1);
            pulse_start(vecs[v].hold_start);
            wait_halted(300);
            start = 1'b0;
            @(negedge clk);
            check("vec_pc",      int'(iram_addr), vecs[v].exp_pc);
            check("vec_fault",   int'(fault), vecs[v].exp_fault);
            check("vec_valid",   int'(instr_valid), 0);
            check("vec_jt_cnt",  jt_cnt, vecs[v].exp_jt);
            check("vec_pending", exp_q.size(), 0);
        end

        // Linear timing: valid 2 edges after FETCH_WAIT, next issue 3 edges later.
        do_reset(0);
        instr_ready = 1'b1;
        exp_q.push_back(OP_CLAC);
        exp_q.push_back(OP_INAC);
        pulse_start(1'b0);
        cyc = 0;
        do begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end while (!instr_valid && cyc < 20);
        check("lin_first_latency", cyc, 2);
        check("lin_first_op", int'(instr_opcode), int'(OP_CLAC));
        cyc = 0;
        do begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end while (!instr_valid && cyc < 20);
        check("lin_second_spacing", cyc, 3);
        wait_halted(50);
        check("lin_halt_pc", int'(iram_addr), 2);

        // Back-pressure on the second opcode.
        do_reset(0);
        instr_ready = 1'b1;
        exp_q.push_back(OP_CLAC);
        exp_q.push_back(OP_INAC);
        pulse_start(1'b0);
        cyc = 0;
        while (!(instr_valid && instr_opcode == OP_CLAC) && cyc < 20) begin
            @(negedge clk); cyc++;
        end
        @(posedge clk); #1;
        instr_ready = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
        end while (!instr_valid && cyc < 20);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",  int'(instr_valid), 1);
            check("bp_opcode", int'(instr_opcode), int'(OP_INAC));
            check("bp_pc",     int'(iram_addr), 2);
            @(negedge clk);
        end
        @(posedge clk); #1;
        instr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_next_addr", int'(iram_addr), 2);
        check("bp_valid_drop", int'(instr_valid), 0);
        wait_halted(50);
        check("bp_pending", exp_q.size(), 0);

        // Unconditional jump: 4 cycles from FETCH_WAIT to target, no issue.
        do_reset(1);
        z_flag = 1'b1;
        exp_q.push_back(OP_INAC);
        pulse_start(1'b0);
        cyc = 0;
        do begin
            @(posedge clk); cyc++;
            @(negedge clk);
            check("jmp_no_valid", int'(instr_valid), 0);
        end while (iram_addr != 8'd103 && cyc < 20);
        check("jmp_cycles", cyc, 4);
        check("jmp_pulse", int'(jump_taken), 1);
        @(negedge clk);
        check("jmp_pulse_end", int'(jump_taken), 0);
        wait_halted(100);
        check("jmp_fault", int'(fault), 1);

        // Async reset mid-ISSUE, then refetch from address 0.
        do_reset(0);
        instr_ready = 1'b0;
        pulse_start(1'b0);
        cyc = 0;
        while (!instr_valid && cyc < 20) begin
            @(negedge clk); cyc++;
        end
        check("mid_issue_valid", int'(instr_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_issue_rst_valid",  int'(instr_valid), 0);
        check("mid_issue_rst_opcode", int'(instr_opcode), 0);
        check("mid_issue_rst_addr",   int'(iram_addr), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        instr_ready = 1'b1;
        exp_q.push_back(OP_CLAC);
        exp_q.push_back(OP_INAC);
        pulse_start(1'b0);
        wait_halted(50);
        check("mid_issue_refetch_pc", int'(iram_addr), 2);
        check("mid_issue_pending", exp_q.size(), 0);

        // Async reset mid-OPND abandons the jump.
        do_reset(1);
        z_flag = 1'b1;
        pulse_start(1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_opnd_rst_addr", int'(iram_addr), 0);
        @(negedge clk);
        check("mid_opnd_rst_jt",   int'(jump_taken), 0);
        check("mid_opnd_rst_halt", int'(halted), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        jt_cnt = 0;
        exp_q.push_back(OP_INAC);
        pulse_start(1'b0);
        wait_halted(100);
        @(negedge clk);
        check("mid_opnd_refetch_pc", int'(iram_addr), 121);
        check("mid_opnd_refetch_jt", jt_cnt, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
